uart_tx_scheduler: RTL and testbench

Sequencer and arbiter that shares the single UART serializer (the `TransmitData` start/data/busy interface) between three message requesters. Requesters are the digit echo path, the calculator result path and the status path. Each requester presents up to eight BCD digits. The block grants one requester at a time, round-robin, snapshots its digits and emits them as ASCII bytes, most significant first, with an optional trailing CR. It sits between the receive/transmit front end and the serializer and replaces per-requester direct drive of `txdStart`/`txdData`.

---
 rtl/uart_tx_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART serializer between three BCD message
// requesters, sending each message as ASCII digits (MSD first) with an optional CR.
module uart_tx_scheduler #(
    parameter bit APPEND_CR     = 1'b1,
    parameter int START_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [11:0] req_len,
    input  logic [95:0] req_digits,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        NEXT,
        DONE
    } state_t;

    localparam logic [7:0] TIMEOUT_LOAD = 8'(START_TIMEOUT);

    state_t      state, state_n;
    logic [1:0]  win, win_n;
    logic [1:0]  last, last_n;
    logic [1:0]  pick;
    logic [31:0] digits, digits_n;
    logic [31:0] sel_digits;
    logic [3:0]  sel_len, len_c;
    logic [3:0]  idx, idx_n, idx_inc;
    logic [7:0]  cnt, cnt_n;
    logic [7:0]  tx_data_q, tx_data_n;
    logic [2:0]  win_onehot;

    // Digit 7 sits in the low nibble, so digit i is found 4*i bits below the top.
    function automatic logic [7:0] ascii_byte(input logic [31:0] d, input logic [3:0] i);
        logic [3:0] nib;
        nib = 4'd0;
        case (i[2:0])
            3'd0: nib = d[31:28];
            3'd1: nib = d[27:24];
            3'd2: nib = d[23:20];
            3'd3: nib = d[19:16];
            3'd4: nib = d[15:12];
            3'd5: nib = d[11:8];
            3'd6: nib = d[7:4];
            default: nib = d[3:0];
        endcase
        ascii_byte = i[3] ? 8'h0D : {4'b0011, nib};
    endfunction

    // Round-robin search starts at the requester after the last one served.
    always_comb begin
        pick = 2'd0;
        case (last)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        sel_digits = 32'd0;
        sel_len    = 4'd0;
        case (win)
            2'd0: begin
                sel_digits = req_digits[31:0];
                sel_len    = req_len[3:0];
            end
            2'd1: begin
                sel_digits = req_digits[63:32];
                sel_len    = req_len[7:4];
            end
            2'd2: begin
                sel_digits = req_digits[95:64];
                sel_len    = req_len[11:8];
            end
            default: begin
                sel_digits = 32'd0;
                sel_len    = 4'd0;
            end
        endcase
        len_c = (sel_len > 4'd8) ? 4'd8 : sel_len;
    end

    assign idx_inc    = idx + 4'd1;
    assign win_onehot = 3'b001 << win;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            win       <= 2'd0;
            last      <= 2'd2;
            digits    <= 32'd0;
            idx       <= 4'd0;
            cnt       <= 8'd0;
            tx_data_q <= 8'h00;
        end else begin
            state     <= state_n;
            win       <= win_n;
            last      <= last_n;
            digits    <= digits_n;
            idx       <= idx_n;
            cnt       <= cnt_n;
            tx_data_q <= tx_data_n;
        end
    end

    // tx_data is loaded on entry to ISSUE so it is valid with the start pulse and
    // holds until the next one.
    always_comb begin
        state_n   = state;
        win_n     = win;
        last_n    = last;
        digits_n  = digits;
        idx_n     = idx;
        cnt_n     = cnt;
        tx_data_n = tx_data_q;
        case (state)
            IDLE: begin
                if (|req) begin
                    win_n   = pick;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                digits_n = sel_digits;
                idx_n    = 4'd8 - len_c;
                last_n   = win;
                if ((len_c == 4'd0) && !APPEND_CR) begin
                    state_n = DONE;
                end else begin
                    tx_data_n = ascii_byte(sel_digits, 4'd8 - len_c);
                    state_n   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = TIMEOUT_LOAD;
                state_n = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy) begin
                    state_n = WAIT_LO;
                end else if (cnt <= 8'd1) begin
                    state_n = NEXT;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    state_n = NEXT;
                end
            end
            NEXT: begin
                idx_n = idx_inc;
                if ((idx_inc < 4'd8) || ((idx_inc == 4'd8) && APPEND_CR)) begin
                    tx_data_n = ascii_byte(digits, idx_inc);
                    state_n   = ISSUE;
                end else begin
                    state_n = DONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy     = (state != IDLE);
    assign tx_start = (state == ISSUE);
    assign tx_data  = tx_data_q;
    assign grant    = ((state != IDLE) && (state != DONE)) ? win_onehot : 3'b000;
    assign done     = (state == DONE) ? win_onehot : 3'b000;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a simple serializer model drives tx_busy
// and a high-level model predicts bytes, grant order and cycle timing.
module tb_uart_tx_scheduler;

    localparam bit APPEND_CR     = 1'b1;
    localparam int START_TIMEOUT = 16;
    localparam int BUSY_LEN      = 10;
    // busy rises one cycle after the pulse, stays BUSY_LEN cycles, then NEXT and ISSUE
    localparam int BYTE_GAP      = BUSY_LEN + 3;
    localparam int TO_GAP        = START_TIMEOUT + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [11:0] req_len = 12'd0;
    logic [95:0] req_digits = 96'd0;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        busy;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int proto_errs = 0;
    bit ser_on = 1'b1;
    int ser_cnt = 0;
    bit ser_pend = 1'b0;
    bit prev_start = 1'b0;
    logic [2:0] prev_grant = 3'b000;

    int         st_cyc[$];
    logic [7:0] st_dat[$];
    int         dn_cyc[$];
    logic [2:0] dn_who[$];
    logic [2:0] gr_who[$];
    logic [7:0] exp_q[$];

    uart_tx_scheduler #(
        .APPEND_CR(APPEND_CR),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .req_len(req_len),
        .req_digits(req_digits),
        .grant(grant),
        .done(done),
        .busy(busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Serializer model: busy rises the cycle after a start pulse and stays high BUSY_LEN cycles.
    always @(negedge clk) begin
        if (!reset) begin
            ser_cnt  = 0;
            ser_pend = 1'b0;
            tx_busy  = 1'b0;
        end else begin
            if (ser_cnt > 0) ser_cnt = ser_cnt - 1;
            if (ser_pend) begin
                ser_cnt  = BUSY_LEN;
                ser_pend = 1'b0;
            end
            if (tx_start && ser_on) ser_pend = 1'b1;
            tx_busy = (ser_cnt > 0);
        end
    end

    always @(negedge clk) begin
        if (tx_start) begin
            st_cyc.push_back(cyc);
            st_dat.push_back(tx_data);
            if (prev_start) proto_errs++;
        end
        prev_start = tx_start;
        if (done != 3'b000) begin
            dn_cyc.push_back(cyc);
            dn_who.push_back(done);
        end
        if ((grant != 3'b000) && (prev_grant == 3'b000)) gr_who.push_back(grant);
        prev_grant = grant;
        if (!$onehot0(grant) || !$onehot0(done)) proto_errs++;
    end

    function automatic void clear_log();
        st_cyc.delete();
        st_dat.delete();
        dn_cyc.delete();
        dn_who.delete();
        gr_who.delete();
    endfunction

    // Expected message: clamped count of trailing digits, MSD first, as '0'+nibble, then CR.
    function automatic void model_bytes(input int len, input logic [31:0] dig);
        int l;
        l = (len > 8) ? 8 : len;
        exp_q.delete();
        for (int k = 8 - l; k < 8; k++) exp_q.push_back(8'h30 + 8'((dig >> (4 * (7 - k))) & 32'hF));
        if (APPEND_CR) exp_q.push_back(8'h0D);
    endfunction

    function automatic int rr_next(input int last_p, input logic [2:0] pend);
        int c;
        for (int k = 1; k <= 3; k++) begin
            c = (last_p + k) % 3;
            if (pend[c]) return c;
        end
        return -1;
    endfunction

    task automatic send_msg(input int r, input logic [3:0] len, input logic [31:0] dig,
                            input int budget, output bit to, output int rc);
        clear_log();
        req_len[r*4 +: 4]     = len;
        req_digits[r*32 +: 32] = dig;
        req[r] = 1'b1;
        rc = cyc;
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done[r]) begin
                to = 1'b0;
                break;
            end
        end
        req[r] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (grant !== 3'b000) $display("[TB] FAIL reset_grant: got %b want 000", grant); else n_pass++;
        n_checks++; if (done !== 3'b000) $display("[TB] FAIL reset_done: got %b want 000", done); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (tx_start !== 1'b0) $display("[TB] FAIL reset_tx_start: got %b want 0", tx_start); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("[TB] FAIL reset_tx_data: got %h want 00", tx_data); else n_pass++;
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit to;
        int rc, first, last_st, dc;
        model_bytes(3, 32'h0000_0456);
        send_msg(0, 4'd3, 32'h0000_0456, 400, to, rc);
        first   = (st_cyc.size() > 0) ? st_cyc[0] : -1;
        last_st = (st_cyc.size() > 0) ? st_cyc[st_cyc.size()-1] : -1;
        dc      = (dn_cyc.size() > 0) ? dn_cyc[0] : -1;
        n_checks++; if (to) $display("[TB] FAIL single_timeout: done[0] not seen in budget"); else n_pass++;
        n_checks++; if (st_dat.size() != exp_q.size()) $display("[TB] FAIL single_count: got %0d starts want %0d", st_dat.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < st_dat.size()) begin
            n_checks++; if (st_dat[i] !== exp_q[i]) $display("[TB] FAIL single_byte%0d: got %h want %h", i, st_dat[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (first != rc + 2) $display("[TB] FAIL single_first_latency: got cycle %0d want %0d", first, rc + 2); else n_pass++;
        for (int i = 1; i < st_cyc.size(); i++) begin
            n_checks++; if (st_cyc[i] - st_cyc[i-1] != BYTE_GAP) $display("[TB] FAIL single_gap%0d: got %0d want %0d", i, st_cyc[i] - st_cyc[i-1], BYTE_GAP); else n_pass++;
        end
        n_checks++; if (dn_who.size() != 1 || dn_who[0] !== 3'b001) $display("[TB] FAIL single_done: got %0d pulses want one on 001", dn_who.size()); else n_pass++;
        n_checks++; if (dc != last_st + BYTE_GAP) $display("[TB] FAIL single_done_cycle: got %0d want %0d", dc, last_st + BYTE_GAP); else n_pass++;
    endtask

    task automatic test_clamp();
        bit to;
        int rc;
        model_bytes(15, 32'h1234_567A);
        send_msg(1, 4'hF, 32'h1234_567A, 400, to, rc);
        n_checks++; if (to) $display("[TB] FAIL clamp_timeout: done[1] not seen in budget"); else n_pass++;
        n_checks++; if (st_dat.size() != 9) $display("[TB] FAIL clamp_count: got %0d starts want 9", st_dat.size()); else n_pass++;
        foreach (exp_q[i]) if (i < st_dat.size()) begin
            n_checks++; if (st_dat[i] !== exp_q[i]) $display("[TB] FAIL clamp_byte%0d: got %h want %h", i, st_dat[i], exp_q[i]); else n_pass++;
        end
        n_checks++; if (dn_who.size() != 1 || dn_who[0] !== 3'b010) $display("[TB] FAIL clamp_done: got %0d pulses want one on 010", dn_who.size()); else n_pass++;
    endtask

    task automatic test_snapshot();
        bit seen, fin;
        seen = 1'b0;
        fin  = 1'b0;
        clear_log();
        model_bytes(1, 32'h0000_0009);
        req_len[3:0]     = 4'd1;
        req_digits[31:0] = 32'h0000_0009;
        req[0] = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = grant[0];
        end
        n_checks++; if (!seen) $display("[TB] FAIL snapshot_grant: got no grant[0] want grant within 20 cycles"); else n_pass++;
        @(negedge clk);
        req_digits[31:0] = 32'h0000_0001;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(negedge clk);
            fin = done[0];
        end
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (!fin) $display("[TB] FAIL snapshot_timeout: done[0] not seen in budget"); else n_pass++;
        n_checks++; if (st_dat.size() != exp_q.size()) $display("[TB] FAIL snapshot_count: got %0d want %0d", st_dat.size(), exp_q.size()); else n_pass++;
        if (st_dat.size() > 0) begin
            n_checks++; if (st_dat[0] !== exp_q[0]) $display("[TB] FAIL snapshot_byte: got %h want %h", st_dat[0], exp_q[0]); else n_pass++;
        end
    endtask

    task automatic test_random();
        bit to;
        int rc, r, len;
        logic [31:0] dig;
        for (int m = 0; m < 8; m++) begin
            r   = $urandom_range(0, 2);
            len = $urandom_range(0, 15);
            dig = $urandom;
            model_bytes(len, dig);
            send_msg(r, 4'(len), dig, 400, to, rc);
            n_checks++; if (to) $display("[TB] FAIL rand%0d_timeout: done[%0d] not seen in budget", m, r); else n_pass++;
            n_checks++; if (st_dat.size() != exp_q.size()) $display("[TB] FAIL rand%0d_count: got %0d want %0d (len %0d)", m, st_dat.size(), exp_q.size(), len); else n_pass++;
            foreach (exp_q[i]) if (i < st_dat.size()) begin
                n_checks++; if (st_dat[i] !== exp_q[i]) $display("[TB] FAIL rand%0d_byte%0d: got %h want %h", m, i, st_dat[i], exp_q[i]); else n_pass++;
            end
            n_checks++; if (dn_who.size() != 1 || dn_who[0] !== 3'(1 << r)) $display("[TB] FAIL rand%0d_done: got %0d pulses want one for requester %0d", m, dn_who.size(), r); else n_pass++;
        end
    endtask

    task automatic test_timeout();
        bit to;
        int rc, last_st, dc;
        logic [31:0] dig;
        dig = $urandom;
        ser_on = 1'b0;
        model_bytes(2, dig);
        send_msg(0, 4'd2, dig, 400, to, rc);
        ser_on = 1'b1;
        last_st = (st_cyc.size() > 0) ? st_cyc[st_cyc.size()-1] : -1;
        dc      = (dn_cyc.size() > 0) ? dn_cyc[0] : -1;
        n_checks++; if (to) $display("[TB] FAIL timeout_done_missing: done[0] not seen in budget"); else n_pass++;
        n_checks++; if (st_dat.size() != exp_q.size()) $display("[TB] FAIL timeout_count: got %0d want %0d", st_dat.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < st_dat.size()) begin
            n_checks++; if (st_dat[i] !== exp_q[i]) $display("[TB] FAIL timeout_byte%0d: got %h want %h", i, st_dat[i], exp_q[i]); else n_pass++;
        end
        for (int i = 1; i < st_cyc.size(); i++) begin
            n_checks++; if (st_cyc[i] - st_cyc[i-1] != TO_GAP) $display("[TB] FAIL timeout_gap%0d: got %0d want %0d", i, st_cyc[i] - st_cyc[i-1], TO_GAP); else n_pass++;
        end
        n_checks++; if (dc != last_st + TO_GAP) $display("[TB] FAIL timeout_done_cycle: got %0d want %0d", dc, last_st + TO_GAP); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] dig [3];
        int exp_who[5];
        int last_m, ndone;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            dig[p] = $urandom;
            req_len[p*4 +: 4]     = 4'd1;
            req_digits[p*32 +: 32] = dig[p];
        end
        last_m = 2;
        for (int m = 0; m < 5; m++) begin
            exp_who[m] = rr_next(last_m, 3'b111);
            last_m = exp_who[m];
        end
        clear_log();
        ndone = 0;
        req = 3'b111;
        for (int i = 0; i < 1000 && ndone < 5; i++) begin
            @(negedge clk);
            if (done != 3'b000) ndone++;
        end
        req = 3'b000;
        repeat (2) @(negedge clk);
        n_checks++; if (ndone != 5) $display("[TB] FAIL rr_done_count: got %0d want 5", ndone); else n_pass++;
        n_checks++; if (st_dat.size() != 10) $display("[TB] FAIL rr_start_count: got %0d want 10", st_dat.size()); else n_pass++;
        for (int m = 0; m < 5; m++) begin
            if (m < gr_who.size()) begin
                n_checks++; if (gr_who[m] !== 3'(1 << exp_who[m])) $display("[TB] FAIL rr_grant%0d: got %b want %b", m, gr_who[m], 3'(1 << exp_who[m])); else n_pass++;
            end
            if (m < dn_who.size()) begin
                n_checks++; if (dn_who[m] !== 3'(1 << exp_who[m])) $display("[TB] FAIL rr_done%0d: got %b want %b", m, dn_who[m], 3'(1 << exp_who[m])); else n_pass++;
            end
            model_bytes(1, dig[exp_who[m]]);
            if (2*m + 1 < st_dat.size()) begin
                n_checks++; if (st_dat[2*m] !== exp_q[0] || st_dat[2*m+1] !== exp_q[1]) $display("[TB] FAIL rr_msg%0d: got %h %h want %h %h", m, st_dat[2*m], st_dat[2*m+1], exp_q[0], exp_q[1]); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int rc, first;
        bit fin;
        logic [31:0] dig;
        dig = $urandom;
        model_bytes(4, dig);
        clear_log();
        req_len[3:0]     = 4'd4;
        req_digits[31:0] = dig;
        req[0] = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (st_cyc.size() >= 2) break;
        end
        repeat (4) @(negedge clk);
        n_checks++; if (st_cyc.size() != 2) $display("[TB] FAIL rmid_pre_starts: got %0d want 2", st_cyc.size()); else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++; if (grant !== 3'b000) $display("[TB] FAIL rmid_grant: got %b want 000", grant); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("[TB] FAIL rmid_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (tx_start !== 1'b0) $display("[TB] FAIL rmid_tx_start: got %b want 0", tx_start); else n_pass++;
        n_checks++; if (tx_data !== 8'h00) $display("[TB] FAIL rmid_tx_data: got %h want 00", tx_data); else n_pass++;
        n_checks++; if (done !== 3'b000 || dn_who.size() != 0) $display("[TB] FAIL rmid_done: got %b (%0d pulses) want none", done, dn_who.size()); else n_pass++;
        repeat (2) @(negedge clk);
        clear_log();
        reset = 1'b1;
        rc  = cyc;
        fin = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(negedge clk);
            fin = done[0];
        end
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        first = (st_cyc.size() > 0) ? st_cyc[0] : -1;
        n_checks++; if (!fin) $display("[TB] FAIL rmid_restart_timeout: done[0] not seen in budget"); else n_pass++;
        n_checks++; if (first != rc + 2) $display("[TB] FAIL rmid_first_latency: got cycle %0d want %0d", first, rc + 2); else n_pass++;
        n_checks++; if (st_dat.size() != exp_q.size()) $display("[TB] FAIL rmid_count: got %0d want %0d", st_dat.size(), exp_q.size()); else n_pass++;
        foreach (exp_q[i]) if (i < st_dat.size()) begin
            n_checks++; if (st_dat[i] !== exp_q[i]) $display("[TB] FAIL rmid_byte%0d: got %h want %h", i, st_dat[i], exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_protocol();
        n_checks++; if (proto_errs != 0) $display("[TB] FAIL protocol: got %0d violations (double start or multi-hot grant/done) want 0", proto_errs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_clamp();
        test_snapshot();
        test_random();
        test_timeout();
        test_round_robin();
        test_reset_mid();
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
